// File: rtl/bambu_init_pkg.sv
// Shared types and defaults for the slave-memory bus initiator.
package bambu_init_pkg;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;
    localparam int SIZE_W = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    // LSB position of lane `lane` in a flat vector of `width`-bit lanes.
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/bambu_lane_mux.sv
// Steers the captured request fields onto the selected channel lane (all
// other lanes zero) and picks that channel's read data / ready back out.
module bambu_lane_mux #(
    parameter int CHANNELS = 2,
    parameter int ADDR_W   = bambu_init_pkg::ADDR_W,
    parameter int DATA_W   = bambu_init_pkg::DATA_W,
    parameter int SIZE_W   = bambu_init_pkg::SIZE_W,
    parameter int CHAN_W   = 2
) (
    input  logic                       en_i,
    input  logic                       oe_i,
    input  logic                       we_i,
    input  logic [CHAN_W-1:0]          chan_i,
    input  logic [ADDR_W-1:0]          addr_i,
    input  logic [SIZE_W-1:0]          size_i,
    input  logic [DATA_W-1:0]          wdata_i,
    input  logic [CHANNELS*DATA_W-1:0] rdata_lanes_i,
    input  logic [CHANNELS-1:0]        rdy_lanes_i,
    output logic [CHANNELS-1:0]        oe_o,
    output logic [CHANNELS-1:0]        we_o,
    output logic [CHANNELS*ADDR_W-1:0] addr_o,
    output logic [CHANNELS*SIZE_W-1:0] size_o,
    output logic [CHANNELS*DATA_W-1:0] wdata_o,
    output logic [DATA_W-1:0]          rdata_o,
    output logic                       rdy_o
);
    import bambu_init_pkg::*;

    // One-hot lane select; an out-of-range channel selects nothing.
    logic [CHANNELS-1:0] sel;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
        assign sel[g]  = (chan_i == CHAN_W'(g));
        assign oe_o[g] = oe_i & sel[g];
        assign we_o[g] = we_i & sel[g];
        assign addr_o[lane_lsb(g, ADDR_W) +: ADDR_W]  = (en_i && sel[g]) ? addr_i  : '0;
        assign size_o[lane_lsb(g, SIZE_W) +: SIZE_W]  = (en_i && sel[g]) ? size_i  : '0;
        assign wdata_o[lane_lsb(g, DATA_W) +: DATA_W] = (en_i && sel[g]) ? wdata_i : '0;
    end

    // Completion from other channels is ignored by construction.
    assign rdy_o = |(rdy_lanes_i & sel);

    // Read-data lane select.
    always_comb begin
        rdata_o = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (sel[i]) rdata_o = rdata_lanes_i[lane_lsb(i, DATA_W) +: DATA_W];
        end
    end

endmodule

// File: rtl/bambu_slave_mem_initiator.sv
// Single-outstanding bus initiator for the slave memory port of an HLS top.
// Optional macro BAMBU_INIT_TIMEOUT_EN: abandon a request with rsp_err after
// TIMEOUT cycles in WAIT without DataRdy.
module bambu_slave_mem_initiator #(
    parameter int CHANNELS = 2,
    parameter int ADDR_W   = bambu_init_pkg::ADDR_W,
    parameter int DATA_W   = bambu_init_pkg::DATA_W,
    parameter int SIZE_W   = bambu_init_pkg::SIZE_W,
    parameter int TIMEOUT  = 1023,
    // One extra bit so out-of-range channel numbers are representable and
    // can be answered with rsp_err instead of aliasing onto a real lane.
    localparam int CHAN_W  = $clog2(CHANNELS) + 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_we,
    input  logic [CHAN_W-1:0]          cmd_chan,
    input  logic [ADDR_W-1:0]          cmd_addr,
    input  logic [SIZE_W-1:0]          cmd_size,
    input  logic [DATA_W-1:0]          cmd_wdata,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [DATA_W-1:0]          rsp_rdata,
    output logic                       rsp_err,
    output logic [CHANNELS-1:0]        S_oe_ram,
    output logic [CHANNELS-1:0]        S_we_ram,
    output logic [CHANNELS*ADDR_W-1:0] S_addr_ram,
    output logic [CHANNELS*DATA_W-1:0] S_Wdata_ram,
    output logic [CHANNELS*SIZE_W-1:0] S_data_ram_size,
    input  logic [CHANNELS*DATA_W-1:0] Sout_Rdata_ram,
    input  logic [CHANNELS-1:0]        Sout_DataRdy
);
    import bambu_init_pkg::*;

    state_e              state_q, state_d;
    logic                we_q, we_d;
    logic [CHAN_W-1:0]   chan_q, chan_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [SIZE_W-1:0]   size_q, size_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                up_q;
    logic                chan_ok;
    logic                lane_rdy;
    logic [DATA_W-1:0]   lane_rdata;

`ifdef BAMBU_INIT_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]    cnt_q, cnt_d;
`else
    logic                unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    assign chan_ok   = ({1'b0, cmd_chan} < (CHAN_W + 1)'(CHANNELS));
    // up_q holds cmd_ready low until the first edge after reset release.
    assign cmd_ready = up_q && (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    // Lanes carry the request from ISSUE through RESP; strobes only in ISSUE.
    bambu_lane_mux #(
        .CHANNELS (CHANNELS),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .SIZE_W   (SIZE_W),
        .CHAN_W   (CHAN_W)
    ) u_lanes (
        .en_i          (state_q != S_IDLE),
        .oe_i          ((state_q == S_ISSUE) && !we_q),
        .we_i          ((state_q == S_ISSUE) && we_q),
        .chan_i        (chan_q),
        .addr_i        (addr_q),
        .size_i        (size_q),
        .wdata_i       (wdata_q),
        .rdata_lanes_i (Sout_Rdata_ram),
        .rdy_lanes_i   (Sout_DataRdy),
        .oe_o          (S_oe_ram),
        .we_o          (S_we_ram),
        .addr_o        (S_addr_ram),
        .size_o        (S_data_ram_size),
        .wdata_o       (S_Wdata_ram),
        .rdata_o       (lane_rdata),
        .rdy_o         (lane_rdy)
    );

    // Next-state and response logic for the IDLE/ISSUE/WAIT/RESP sequence.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        chan_d  = chan_q;
        addr_d  = addr_q;
        size_d  = size_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
`ifdef BAMBU_INIT_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd_valid && up_q) begin
                    we_d    = cmd_we;
                    chan_d  = cmd_chan;
                    addr_d  = cmd_addr;
                    size_d  = cmd_size;
                    wdata_d = cmd_wdata;
                    rdata_d = '0;
                    err_d   = !chan_ok;
                    state_d = chan_ok ? S_ISSUE : S_RESP;
                end
            end
            S_ISSUE: begin
                // DataRdy during the strobe cycle is deliberately not looked at.
                state_d = S_WAIT;
`ifdef BAMBU_INIT_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            S_WAIT: begin
                if (lane_rdy) begin
                    rdata_d = we_q ? '0 : lane_rdata;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end
`ifdef BAMBU_INIT_TIMEOUT_EN
                else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_W'(TIMEOUT)) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end
                end
`endif
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rdata_d = '0;
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and captured-request registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            chan_q  <= '0;
            addr_q  <= '0;
            size_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            up_q    <= 1'b0;
`ifdef BAMBU_INIT_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            chan_q  <= chan_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            up_q    <= 1'b1;
`ifdef BAMBU_INIT_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

endmodule
